// File: rtl/sum_display_driver.sv
// Captures a 5-bit adder result, converts it to two BCD digits with a
// sequential double-dabble, and scans them onto a 2-digit 7-segment display.
module sum_display_driver #(
  parameter int REFRESH_DIV    = 100000,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] sum_in,
  input  logic       cout_in,
  input  logic       load,
  output logic       ready,
  output logic [4:0] value_q,
  output logic [6:0] seg,
  output logic [1:0] an,
  output logic       dbg_state
);

  localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] REFRESH_LAST = CW'(REFRESH_DIV - 1);

  localparam logic [6:0] SEG_OFF_AL = 7'b1111111;
  localparam logic [6:0] SEG_RST    = SEG_ACTIVE_LOW ? 7'b1000000 : 7'b0111111;
  localparam logic [1:0] AN_RST     = SEG_ACTIVE_LOW ? 2'b10 : 2'b01;

  typedef enum logic {IDLE = 1'b0, CONV = 1'b1} state_t;

  state_t        state, state_n;
  logic [4:0]    value_n;
  logic [12:0]   sr, sr_n, sr_adj, sr_shift;
  logic [2:0]    shift_cnt, shift_cnt_n;
  logic [3:0]    tens, tens_n, ones, ones_n;
  logic [CW-1:0] refresh_cnt, refresh_cnt_n;
  logic          digit_sel, digit_sel_n;
  logic [6:0]    seg_al, seg_n;
  logic [1:0]    an_al, an_n;

  // Active-low glyph lookup; anything outside 0..9 renders blank.
  function automatic logic [6:0] glyph(input logic [3:0] d);
    case (d)
      4'd0:    glyph = 7'b1000000;
      4'd1:    glyph = 7'b1111001;
      4'd2:    glyph = 7'b0100100;
      4'd3:    glyph = 7'b0110000;
      4'd4:    glyph = 7'b0011001;
      4'd5:    glyph = 7'b0010010;
      4'd6:    glyph = 7'b0000010;
      4'd7:    glyph = 7'b1111000;
      4'd8:    glyph = 7'b0000000;
      4'd9:    glyph = 7'b0010000;
      default: glyph = SEG_OFF_AL;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      value_q     <= '0;
      sr          <= '0;
      shift_cnt   <= '0;
      tens        <= '0;
      ones        <= '0;
      refresh_cnt <= '0;
      digit_sel   <= 1'b0;
      seg         <= SEG_RST;
      an          <= AN_RST;
    end else begin
      state       <= state_n;
      value_q     <= value_n;
      sr          <= sr_n;
      shift_cnt   <= shift_cnt_n;
      tens        <= tens_n;
      ones        <= ones_n;
      refresh_cnt <= refresh_cnt_n;
      digit_sel   <= digit_sel_n;
      seg         <= seg_n;
      an          <= an_n;
    end
  end

  // Add-3 correction on both BCD nibbles before each shift.
  always_comb begin
    sr_adj = sr;
    if (sr[8:5] >= 4'd5)  sr_adj[8:5]  = sr[8:5] + 4'd3;
    if (sr[12:9] >= 4'd5) sr_adj[12:9] = sr[12:9] + 4'd3;
    sr_shift = sr_adj << 1;
  end

  always_comb begin
    state_n     = state;
    value_n     = value_q;
    sr_n        = sr;
    shift_cnt_n = shift_cnt;
    tens_n      = tens;
    ones_n      = ones;
    case (state)
      IDLE: begin
        if (load) begin
          value_n     = {cout_in, sum_in};
          sr_n        = {8'b0, cout_in, sum_in};
          shift_cnt_n = '0;
          state_n     = CONV;
        end
      end
      CONV: begin
        sr_n        = sr_shift;
        shift_cnt_n = shift_cnt + 3'd1;
        // Digits update only after the fifth shift so no partial value is shown.
        if (shift_cnt == 3'd4) begin
          tens_n  = sr_shift[12:9];
          ones_n  = sr_shift[8:5];
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    refresh_cnt_n = refresh_cnt + CW'(1);
    digit_sel_n   = digit_sel;
    if (refresh_cnt == REFRESH_LAST) begin
      refresh_cnt_n = '0;
      digit_sel_n   = ~digit_sel;
    end
  end

  // Output registers are fed from next-state values so they track this edge.
  always_comb begin
    if (digit_sel_n) begin
      seg_al = (tens_n == 4'd0) ? SEG_OFF_AL : glyph(tens_n);
      an_al  = 2'b01;
    end else begin
      seg_al = glyph(ones_n);
      an_al  = 2'b10;
    end
    seg_n = SEG_ACTIVE_LOW ? seg_al : ~seg_al;
    an_n  = SEG_ACTIVE_LOW ? an_al : ~an_al;
  end

  assign ready     = (state == IDLE);
  assign dbg_state = state;

endmodule

// File: tb/tb_sum_display_driver.sv
// Randomized bench for sum_display_driver: loads are scoreboarded and checked
// against a decimal reference model when the driver returns to ready.
module tb_sum_display_driver;

  logic       clk;
  logic       rst_n;
  logic [3:0] sum_in;
  logic       cout_in;
  logic       load;
  logic       ready;
  logic [4:0] value_q;
  logic [6:0] seg;
  logic [1:0] an;
  logic       dbg_state;

  int checks = 0;
  int passed = 0;

  logic [4:0] exp_q[$];
  logic [4:0] last_val = '0;
  bit         mon_busy = 1'b0;

  localparam logic [6:0] BLANK = 7'b1111111;
  logic [6:0] gl [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                          7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                          7'b0000000, 7'b0010000};

  sum_display_driver #(.REFRESH_DIV(4), .SEG_ACTIVE_LOW(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .sum_in(sum_in), .cout_in(cout_in),
    .load(load), .ready(ready), .value_q(value_q), .seg(seg), .an(an),
    .dbg_state(dbg_state)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic logic [6:0] exp_ones_seg(input int v);
    return gl[v % 10];
  endfunction

  function automatic logic [6:0] exp_tens_seg(input int v);
    return (v / 10 == 0) ? BLANK : gl[v / 10];
  endfunction

  // Compare the currently scanned slot against the model for value v.
  task automatic chk_slot(input string name, input int v);
    if (an == 2'b10)      chk({name, "_ones"}, seg, exp_ones_seg(v));
    else if (an == 2'b01) chk({name, "_tens"}, seg, exp_tens_seg(v));
    else                  chk({name, "_an"}, an, 2'b10);
  endtask

  // monitor / scoreboard
  initial begin
    bit         prev_ready = 1'b1;
    int         busy_cycles = 0;
    logic [4:0] e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_ready  = 1'b1;
        busy_cycles = 0;
      end else if (!ready) begin
        busy_cycles++;
        chk_slot("hold_old", last_val);
        prev_ready = 1'b0;
      end else if (!prev_ready) begin
        prev_ready = 1'b1;
        mon_busy   = 1'b1;
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("value_q", value_q, e);
          chk("busy_len", busy_cycles, 5);
          last_val = e;
          for (int i = 0; i < 8; i++) begin
            if (i > 0) @(negedge clk);
            chk_slot("disp", e);
          end
        end
        busy_cycles = 0;
        mon_busy    = 1'b0;
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!ready) chk("ready_timeout", 0, 1);
  endtask

  task automatic wait_done();
    int n = 0;
    @(negedge clk);
    while ((exp_q.size() != 0 || mon_busy) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0 || mon_busy) chk("done_timeout", 0, 1);
  endtask

  // driver: load at a negedge so the posedge after it is edge k
  task automatic do_load(input logic [4:0] v, input bit busy_pulse, input logic [4:0] bv);
    wait_ready();
    sum_in  = v[3:0];
    cout_in = v[4];
    load    = 1'b1;
    exp_q.push_back(v);
    @(posedge clk); #1;
    load = 1'b0;
    if (busy_pulse) begin
      @(posedge clk); #1;
      sum_in  = bv[3:0];
      cout_in = bv[4];
      load    = 1'b1;
      @(posedge clk); #1;
      load = 1'b0;
    end
  endtask

  initial begin
    rst_n = 1'b0; load = 1'b0; sum_in = '0; cout_in = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    chk("rst_ready", ready, 1);
    chk("rst_value", value_q, 0);
    chk("rst_an", an, 2'b10);
    chk("rst_seg", seg, 7'b1000000);
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      chk("scan_an", an, ((i / 4) % 2) ? 2'b01 : 2'b10);
      chk_slot("scan_idle", 0);
    end

    do_load(5'd23, 1'b0, 5'd0); wait_done();
    do_load(5'd5,  1'b0, 5'd0); wait_done();
    do_load(5'd31, 1'b0, 5'd0); wait_done();
    do_load(5'd0,  1'b0, 5'd0); wait_done();
    do_load(5'd23, 1'b1, 5'd9); wait_done();

    for (int t = 0; t < 20; t++) begin
      do_load(5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
              5'($urandom_range(0, 31)));
      wait_done();
    end

    // reset in the middle of a conversion
    wait_ready();
    sum_in = 4'b0111; cout_in = 1'b1; load = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    last_val = '0;
    chk("abort_ready", ready, 1);
    chk("abort_value", value_q, 0);
    chk("abort_an", an, 2'b10);
    chk("abort_seg", seg, 7'b1000000);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("post_abort_value", value_q, 0);
      chk_slot("post_abort", 0);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
